// File: rtl/dtcm_hs.sv
`timescale 1ns / 1ps
// dtcm_hs: data tightly-coupled memory for the LSU with valid/ready request and
// response handshakes, one access in flight at a time.
//
// Features: per-byte store enables, configurable read latency (RD_LAT = 1..4), and an
// error response for out-of-range addresses or stores with no byte enabled.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   req_valid_from_lsu  request valid
//   req_ready_to_lsu    request accepted when valid & ready
//   req_we_from_lsu     1 = store, 0 = load
//   req_addr_from_lsu   byte address; low log2(NB) bits ignored
//   req_wdata_from_lsu  store data, lane-positioned
//   req_be_from_lsu     store byte enables, bit i = byte i
//   rsp_valid_to_lsu    response valid
//   rsp_ready_from_lsu  response consumed when valid & ready
//   rsp_rdata_to_lsu    load data; 0 for stores, errors and while rsp_valid = 0
//   rsp_err_to_lsu      access error, qualified by rsp_valid
module dtcm_hs #(
    parameter int unsigned     DW        = 32,
    parameter int unsigned     AW        = 32,
    parameter int unsigned     DEPTH     = 1024,
    parameter logic [AW-1:0]   BASE_ADDR = '0,
    parameter int unsigned     RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_from_lsu,
    output logic              req_ready_to_lsu,
    input  logic              req_we_from_lsu,
    input  logic [AW-1:0]     req_addr_from_lsu,
    input  logic [DW-1:0]     req_wdata_from_lsu,
    input  logic [DW/8-1:0]   req_be_from_lsu,
    output logic              rsp_valid_to_lsu,
    input  logic              rsp_ready_from_lsu,
    output logic [DW-1:0]     rsp_rdata_to_lsu,
    output logic              rsp_err_to_lsu
);

    localparam int unsigned NB     = DW / 8;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned OFF_W  = IDX_W + $clog2(NB);
    localparam logic [AW:0] MEM_BYTES = (AW + 1)'(DEPTH * NB);

    typedef enum logic [1:0] {StIdle, StRwait, StRsp, StWrsp} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [DW-1:0]     mem [DEPTH];

    logic [AW-1:0]     off;
    logic [IDX_W-1:0]  idx;
    logic              acc_err;
    logic              accept;
    logic              wr_en;

    // Address decode
    always_comb begin
        off     = req_addr_from_lsu - BASE_ADDR;
        idx     = off[OFF_W-1 -: IDX_W];
        acc_err = ({1'b0, off} >= MEM_BYTES) ||
                  (req_we_from_lsu && (req_be_from_lsu == '0));
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rdata_d          = rdata_q;
        err_d            = err_q;
        req_ready_to_lsu = 1'b0;
        rsp_valid_to_lsu = 1'b0;
        accept           = 1'b0;

        case (state_q)
            StIdle: begin
                req_ready_to_lsu = 1'b1;
            end
            StRwait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StRsp;
                end
            end
            StRsp, StWrsp: begin
                rsp_valid_to_lsu = 1'b1;
                // Same-cycle turnaround: a new request can ride on the response handshake
                req_ready_to_lsu = rsp_ready_from_lsu;
                if (rsp_ready_from_lsu) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // No acceptance while reset is asserted
        if (!rst_n) begin
            req_ready_to_lsu = 1'b0;
        end

        accept = req_valid_from_lsu && req_ready_to_lsu;

        if (accept) begin
            err_d = acc_err;
            if (req_we_from_lsu) begin
                state_d = StWrsp;
                rdata_d = '0;
            end else begin
                // Load data is captured at accept and held through any wait cycles
                rdata_d = acc_err ? '0 : mem[idx];
                if (RD_LAT == 1) begin
                    state_d = StRsp;
                end else begin
                    state_d = StRwait;
                    cnt_d   = 3'(RD_LAT - 1);
                end
            end
        end

        rsp_rdata_to_lsu = rsp_valid_to_lsu ? rdata_q : '0;
        rsp_err_to_lsu   = rsp_valid_to_lsu && err_q;
    end

    assign wr_en = accept && req_we_from_lsu && !acc_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory array: not reset, byte-lane writes
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be_from_lsu[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata_from_lsu[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dtcm_hs.sv
`timescale 1ns / 1ps
// Bench for dtcm_hs: instance 0 has RD_LAT=1, instance 1 has RD_LAT=3.
// Stimulus pushes expected responses into per-instance queues; a monitor pops
// and compares on every response handshake.
module tb_dtcm_hs;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned NB    = 4;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [NB-1:0] req_be    [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [DW-1:0] rsp_rdata [2];
    logic          rsp_err   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dtcm_hs #(
            .DW        (DW),
            .AW        (AW),
            .DEPTH     (DEPTH),
            .BASE_ADDR (32'h0000_0000),
            .RD_LAT    ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .req_valid_from_lsu (req_valid[g]),
            .req_ready_to_lsu   (req_ready[g]),
            .req_we_from_lsu    (req_we[g]),
            .req_addr_from_lsu  (req_addr[g]),
            .req_wdata_from_lsu (req_wdata[g]),
            .req_be_from_lsu    (req_be[g]),
            .rsp_valid_to_lsu   (rsp_valid[g]),
            .rsp_ready_from_lsu (rsp_ready[g]),
            .rsp_rdata_to_lsu   (rsp_rdata[g]),
            .rsp_err_to_lsu     (rsp_err[g])
        );
    end

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push(int k, logic [DW-1:0] rdata, logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    // Monitor: compare every response handshake against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic has;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (!rsp_valid[k]) begin
                    chk("idle_rdata_zero", rsp_rdata[k], 32'd0);
                end else if (rsp_ready[k]) begin
                    has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
                    if (!has) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: inst %0d got rdata %h err %0b expected none",
                                 k, rsp_rdata[k], rsp_err[k]);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk("rsp_rdata", rsp_rdata[k], e.rdata);
                        chk("rsp_err", 32'(rsp_err[k]), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic drive(int k, logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be);
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        req_valid[k] = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the accept edge
    task automatic issue(int k, logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] be,
                         logic [31:0] exp_rdata, logic exp_err);
        logic ok;
        ok = 1'b0;
        drive(k, we, addr, wdata, be);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                push(k, exp_rdata, exp_err);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: inst %0d addr %h got no ready expected ready", k, addr);
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        logic [31:0] d;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_be[k]    = '0;
            rsp_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("reset_req_ready", 32'(req_ready[k]), 32'd1);
        end
        @(posedge clk);
        #1;

        // Byte lanes on both latencies
        for (int k = 0; k < 2; k++) begin
            issue(k, 1'b1, 32'h10, 32'hDDCC_BBAA, 4'hF, 32'h0, 1'b0);
            issue(k, 1'b1, 32'h10, 32'h0000_EE00, 4'h2, 32'h0, 1'b0);
            issue(k, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDDCC_EEAA, 1'b0);
        end
        wait_idle();

        // Read latency 3
        drive(1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        chk("lat_accept", 32'(req_ready[1]), 32'd1);
        push(1, 32'hDDCC_EEAA, 1'b0);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lat_wait_valid", 32'(rsp_valid[1]), 32'd0);
            chk("lat_wait_ready", 32'(req_ready[1]), 32'd0);
        end
        @(negedge clk);
        chk("lat_rsp_valid", 32'(rsp_valid[1]), 32'd1);
        wait_idle();

        // Backpressure on a load response
        rsp_ready[1] = 1'b0;
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDDCC_EEAA, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_valid_seen", 32'(ok), 32'd1);
        @(posedge clk);
        #1 drive(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid[1]), 32'd1);
            chk("bp_hold_rdata", rsp_rdata[1], 32'hDDCC_EEAA);
            chk("bp_hold_err", 32'(rsp_err[1]), 32'd0);
            chk("bp_hold_ready", 32'(req_ready[1]), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("bp_release_accept", 32'(req_ready[1]), 32'd1);
        push(1, 32'h0, 1'b0);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        wait_idle();

        // Reset during RWAIT: pending response is dropped, nothing pushed for it
        drive(1, 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        chk("rst_load_accept", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("rst_in_rwait", 32'(req_ready[1]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid[1]), 32'd0);
        chk("rst_mid_rdata", rsp_rdata[1], 32'd0);
        chk("rst_mid_err", 32'(rsp_err[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_rel_ready", 32'(req_ready[k]), 32'd1);
            chk("rst_rel_valid", 32'(rsp_valid[k]), 32'd0);
        end
        repeat (4) @(negedge clk);
        chk("rst_no_late_rsp", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        #1;
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

        // Error responses
        issue(0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
        issue(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDDCC_EEAA, 1'b0);
        issue(1, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
        issue(1, 1'b1, 32'h1004, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        wait_idle();

        // Streaming at RD_LAT=1: one accept per cycle
        for (int i = 0; i < 16; i++) begin
            d = 32'hC0DE_0000 + 32'(i) * 32'h0101;
            for (int w = 0; w < 2; w++) begin
                drive(0, (w == 0), 32'(i * 4), d, 4'hF);
                @(negedge clk);
                chk("stream_accept", 32'(req_ready[0]), 32'd1);
                if (w == 0) push(0, 32'h0, 1'b0);
                else        push(0, d, 1'b0);
                @(posedge clk);
                #1;
            end
        end
        req_valid[0] = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
